fold_accumulator_mc: RTL and testbench

Multi-channel streaming bitwise fold accumulator. Each beat folds the input word into the accumulator of the addressed channel: acc_next = acc OP in_data.
- The operation is selectable per frame, and an element counter runs per channel.
- A frame closes on in_last, which emits one result beat through a single-entry valid/ready output register.
- Sits between a bit-vector source (switches/packet stream) and display/compare logic.
- Generalises the single-channel, fixed-implication accumulator.

---
 rtl/fold_accumulator_mc.sv | 136 +++++++++++++
 tb/tb_fold_accumulator_mc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fold_accumulator_mc.sv
// rtl/fold_accumulator_mc.sv - multi-channel streaming bitwise fold accumulator with registered result
// Optional FOLD_PEEK_EN adds peek_ch/peek_data for registered accumulator inspection.
module fold_accumulator_mc #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int COUNT_W  = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [CW-1:0]      in_ch,
  input  logic [1:0]         in_op,
  input  logic               in_last,
`ifdef FOLD_PEEK_EN
  input  logic [CW-1:0]      peek_ch,
  output logic [WIDTH-1:0]   peek_data,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  output logic [COUNT_W-1:0] out_count,
  output logic [1:0]         out_op
);

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;

  logic [WIDTH-1:0]   acc_q  [CHANNELS];
  logic [1:0]         op_q   [CHANNELS];
  logic [COUNT_W-1:0] cnt_q  [CHANNELS];
  logic               busy_q [CHANNELS];

  logic               ch_ok;
  logic [CW-1:0]      ch_idx;
  logic               accept;
  logic               cur_busy;
  logic [1:0]         eff_op;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   fold_res;
  logic [COUNT_W-1:0] next_cnt;

  function automatic logic [WIDTH-1:0] neutral(input logic [1:0] op);
    return (op == OP_OR || op == OP_XOR) ? '0 : '1;
  endfunction

  function automatic logic [WIDTH-1:0] fold(input logic [1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] d);
    case (op)
      OP_AND:  return a & d;
      OP_OR:   return a | d;
      OP_XOR:  return a ^ d;
      default: return ~a | d;
    endcase
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign ch_ok    = (32'(in_ch) < CHANNELS);
  // Out-of-range channels are accepted but never touch state; keep the index legal.
  assign ch_idx   = ch_ok ? in_ch : '0;
  assign accept   = in_valid && in_ready && ch_ok;

  always_comb begin
    cur_busy = busy_q[ch_idx];
    eff_op   = cur_busy ? op_q[ch_idx]  : in_op;
    operand  = cur_busy ? acc_q[ch_idx] : neutral(in_op);
    fold_res = fold(eff_op, operand, in_data);
    if (!cur_busy)
      next_cnt = COUNT_W'(1);
    else if (cnt_q[ch_idx] == '1)
      next_cnt = cnt_q[ch_idx];
    else
      next_cnt = cnt_q[ch_idx] + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]  <= '1;
        op_q[i]   <= 2'd3;
        cnt_q[i]  <= '0;
        busy_q[i] <= 1'b0;
      end
    end else if (accept) begin
      op_q[ch_idx] <= eff_op;
      if (in_last) begin
        acc_q[ch_idx]  <= '1;
        cnt_q[ch_idx]  <= '0;
        busy_q[ch_idx] <= 1'b0;
      end else begin
        acc_q[ch_idx]  <= fold_res;
        cnt_q[ch_idx]  <= next_cnt;
        busy_q[ch_idx] <= 1'b1;
      end
    end
  end

  // A new last beat reloads the result register even while it is being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_count <= '0;
      out_op    <= '0;
    end else if (accept && in_last) begin
      out_valid <= 1'b1;
      out_data  <= fold_res;
      out_ch    <= ch_idx;
      out_count <= next_cnt;
      out_op    <= eff_op;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FOLD_PEEK_EN
  logic [CW-1:0] peek_idx;
  assign peek_idx = (32'(peek_ch) < CHANNELS) ? peek_ch : '0;

  always_ff @(posedge clk) begin
    if (rst)
      peek_data <= '1;
    else if (32'(peek_ch) < CHANNELS)
      peek_data <= acc_q[peek_idx];
    else
      peek_data <= '1;
  end
`endif

endmodule

// File: tb/tb_fold_accumulator_mc.sv
// tb/tb_fold_accumulator_mc.sv - scoreboard bench for fold_accumulator_mc
module tb_fold_accumulator_mc;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int COUNT_W  = 3;
  localparam int CW       = 1;

  typedef struct {
    logic [WIDTH-1:0]   data;
    logic [CW-1:0]      ch;
    logic [COUNT_W-1:0] count;
    logic [1:0]         op;
  } res_t;

  logic               clk = 0;
  logic               rst = 1;
  logic               in_valid = 0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data = '0;
  logic [CW-1:0]      in_ch = '0;
  logic [1:0]         in_op = '0;
  logic               in_last = 0;
  logic               out_valid;
  logic               out_ready = 1;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_ch;
  logic [COUNT_W-1:0] out_count;
  logic [1:0]         out_op;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  fold_accumulator_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_count(out_count), .out_op(out_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input int ch, input int op, input logic [WIDTH-1:0] d, input int cnt);
    res_t r;
    r.data  = d;
    r.ch    = CW'(ch);
    r.count = COUNT_W'(cnt);
    r.op    = 2'(op);
    sb.push_back(r);
  endtask

  task automatic beat(input int ch, input int op, input logic [WIDTH-1:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1;
    in_ch    = CW'(ch);
    in_op    = 2'(op);
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("out_data",  32'(out_data),  32'(r.data));
        chk("out_ch",    32'(out_ch),    32'(r.ch));
        chk("out_count", 32'(out_count), 32'(r.count));
        chk("out_op",    32'(out_op),    32'(r.op));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_op",    32'(out_op),    0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    idle(1);

    // ch0 IMPL frame: 1010 -> ~1010|0110=0111 -> ~0111|1100=1100
    beat(0, 3, 4'b1010, 0);
    beat(0, 0, 4'b0110, 0);
    expect_res(0, 3, 4'b1100, 3);
    beat(0, 1, 4'b1100, 1);
    idle(2);

    // Interleaved: ch1 XOR 0011^0101=0110, ch0 IMPL unchanged at 1100
    beat(0, 3, 4'b1010, 0);
    beat(1, 2, 4'b0011, 0);
    beat(0, 2, 4'b0110, 0);
    expect_res(1, 2, 4'b0110, 2);
    beat(1, 0, 4'b0101, 1);
    expect_res(0, 3, 4'b1100, 3);
    beat(0, 0, 4'b1100, 1);
    idle(2);

    // Single-beat AND frame
    expect_res(0, 0, 4'b1001, 1);
    beat(0, 0, 4'b1001, 1);
    idle(2);

    // Backpressure: pending result held, input stalled
    out_ready = 0;
    expect_res(1, 1, 4'b0110, 1);
    beat(1, 1, 4'b0110, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data",  32'(out_data),  32'(4'b0110));
      chk("bp_out_count", 32'(out_count), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    expect_res(0, 2, 4'b0101, 1);
    beat(0, 2, 4'b0101, 1);
    @(negedge clk);
    chk("b2b_out_valid", 32'(out_valid), 1);
    idle(2);

    // Saturating count: 10-beat OR frame, COUNT_W=3 -> count 7
    for (int i = 0; i < 9; i++) beat(0, 1, 4'b0001, 0);
    expect_res(0, 1, 4'b0001, 7);
    beat(0, 1, 4'b0001, 1);
    idle(2);

    // Reset mid-frame with a pending result that must be dropped
    beat(1, 1, 4'b1111, 0);
    beat(1, 1, 4'b0000, 0);
    out_ready = 0;
    beat(0, 1, 4'b0001, 1);
    rst = 1;
    idle(2);
    rst = 0;
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    out_ready = 1;
    expect_res(1, 3, 4'b0100, 1);
    beat(1, 3, 4'b0100, 1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
